// File: rtl/hcounter_source.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hcounter_source                                                 |
// | Brief    : Incrementing-data message source on a 4-phase req/ack channel   |
// |            with ack debouncing; optional HCOUNTER_SOURCE_DBG_ERR_EN adds   |
// |            sticky protocol-error reporting ports.                          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 2
`endif

module hcounter_source #(
    parameter int MY_LOCAL_ADDR = 0,
    parameter int DST_ADDR      = 0,
    parameter int ASZ           = `NS_ADDRESS_SIZE,
    parameter int DSZ           = `NS_DATA_SIZE,
    parameter int RSZ           = `NS_REDUN_SIZE,
    parameter int NUM_MSG       = 16,
    parameter int GAP_CKS       = 2,
    parameter int ACK_CKS       = `NS_REQ_CKS
) (
    input  logic           gch_clk,
    input  logic           gch_reset,
    output logic           gch_ready,
    input  logic           start,
    output logic           snd0_req_out,
    input  logic           snd0_ack_in,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic [15:0]    sent_cnt,
`ifdef HCOUNTER_SOURCE_DBG_ERR_EN
    output logic           err0_error,
    output logic [DSZ-1:0] err0_dat,
    output logic [ASZ-1:0] err0_src,
`endif
    output logic           done
);

    localparam int CW       = $clog2(ACK_CKS + 1);
    localparam int GW       = (GAP_CKS > 1) ? $clog2(GAP_CKS) : 1;
    localparam int GAP_LOAD = (GAP_CKS > 0) ? GAP_CKS - 1 : 0;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_REQ  = 3'd2,
        S_REL  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic            req_q, req_d;
    logic [DSZ-1:0]  dat_q, dat_d;
    logic [15:0]     sent_q, sent_d;
    logic            done_q, done_d;
    logic [GW-1:0]   gap_q, gap_d;

    logic            ack_last_q;
    logic [CW-1:0]   ack_cnt_q, ack_cnt_d;
    logic            ack_ckd_q, ack_ckd_d;
    logic [16:0]     sent_inc_w;

    // Run length of identical raw samples including the current one, saturating at ACK_CKS.
    always_comb begin
        ack_cnt_d = CW'(1);
        if (snd0_ack_in == ack_last_q) begin
            ack_cnt_d = (ack_cnt_q == CW'(ACK_CKS)) ? ack_cnt_q : ack_cnt_q + 1'b1;
        end
        ack_ckd_d = (ack_cnt_d == CW'(ACK_CKS)) ? snd0_ack_in : ack_ckd_q;
    end

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            ack_last_q <= 1'b0;
            ack_cnt_q  <= '0;
            ack_ckd_q  <= 1'b0;
        end else begin
            ack_last_q <= snd0_ack_in;
            ack_cnt_q  <= ack_cnt_d;
            ack_ckd_q  <= ack_ckd_d;
        end
    end

    assign sent_inc_w = {1'b0, sent_q} + 17'd1;

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        dat_d   = dat_q;
        sent_d  = sent_q;
        done_d  = done_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_INIT: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (start && !ack_ckd_q) begin
                    done_d  = 1'b0;
                    sent_d  = '0;
                    dat_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_ckd_q) begin
                    state_d = S_REL;
                end
            end
            S_REL: begin
                if (!ack_ckd_q) begin
                    sent_d = (sent_q == 16'hFFFF) ? sent_q : sent_inc_w[15:0];
                    dat_d  = dat_q + 1'b1;
                    if ((NUM_MSG != 0) && (sent_inc_w == 17'(NUM_MSG))) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (GAP_CKS == 0) begin
                        state_d = S_REQ;
                    end else begin
                        gap_d   = GW'(GAP_LOAD);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (gap_q == '0) begin
                    state_d = S_REQ;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
        // Registered req follows the next state so it drops on the same edge that enters REL.
        req_d = (state_d == S_REQ);
    end

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            state_q <= S_INIT;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
            dat_q   <= '0;
            sent_q  <= '0;
            done_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            dat_q   <= dat_d;
            sent_q  <= sent_d;
            done_q  <= done_d;
            gap_q   <= gap_d;
        end
    end

    assign gch_ready    = ready_q;
    assign snd0_req_out = req_q;
    assign snd0_src     = ASZ'(MY_LOCAL_ADDR);
    assign snd0_dst     = ASZ'(DST_ADDR);
    assign snd0_dat     = dat_q;
    assign snd0_red     = RSZ'(snd0_src) + RSZ'(snd0_dst) + RSZ'(dat_q);
    assign sent_cnt     = sent_q;
    assign done         = done_q;

`ifdef HCOUNTER_SOURCE_DBG_ERR_EN
    logic           err_q;
    logic [DSZ-1:0] err_dat_q;
    logic           err_w;

    // Filtered-ack edges are legal only on rise in REQ and fall in REL.
    assign err_w = ( ack_ckd_d && !ack_ckd_q && (state_q != S_REQ)) ||
                   (!ack_ckd_d &&  ack_ckd_q && (state_q != S_REL));

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            err_q     <= 1'b0;
            err_dat_q <= '0;
        end else if (err_w && !err_q) begin
            err_q     <= 1'b1;
            err_dat_q <= dat_q;
        end
    end

    assign err0_error = err_q;
    assign err0_dat   = err_dat_q;
    assign err0_src   = ASZ'(MY_LOCAL_ADDR);
`endif

endmodule

`default_nettype wire

// File: tb/tb_hcounter_source.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hcounter_source                                              |
// | Brief    : Randomized-responder bench for hcounter_source with a           |
// |            message-level reference model.                                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_hcounter_source;

    localparam int ASZ   = 4;
    localparam int DSZ   = 4;
    localparam int RSZ   = 3;
    localparam int MY    = 5;
    localparam int DST   = 11;
    localparam int NMSG  = 20;
    localparam int GAPC  = 2;
    localparam int ACKC  = 2;

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic           start = 1'b0;
    logic           ack   = 1'b0;
    logic           ready;
    logic           req;
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
    logic [15:0]    sent;
    logic           done;
`ifdef HCOUNTER_SOURCE_DBG_ERR_EN
    logic           err;
    logic [DSZ-1:0] err_dat;
    logic [ASZ-1:0] err_src;
`endif

    hcounter_source #(
        .MY_LOCAL_ADDR (MY),
        .DST_ADDR      (DST),
        .ASZ           (ASZ),
        .DSZ           (DSZ),
        .RSZ           (RSZ),
        .NUM_MSG       (NMSG),
        .GAP_CKS       (GAPC),
        .ACK_CKS       (ACKC)
    ) u_dut (
        .gch_clk      (clk),
        .gch_reset    (rst),
        .gch_ready    (ready),
        .start        (start),
        .snd0_req_out (req),
        .snd0_ack_in  (ack),
        .snd0_src     (src),
        .snd0_dst     (dst),
        .snd0_dat     (dat),
        .snd0_red     (red),
        .sent_cnt     (sent),
`ifdef HCOUNTER_SOURCE_DBG_ERR_EN
        .err0_error   (err),
        .err0_dat     (err_dat),
        .err0_src     (err_src),
`endif
        .done         (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_n    = 0;   // messages completed in the current run

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_dat(input int n);
        return n % (1 << DSZ);
    endfunction

    function automatic int exp_red(input int n);
        return (MY + DST + exp_dat(n)) % (1 << RSZ);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_req(input logic lvl, input int budget, output bit ok);
        int n = 0;
        while (req !== lvl && n < budget) begin
            step();
            n++;
        end
        ok = (req === lvl);
    endtask

    // One full handshake as seen by a responder with random latencies.
    task automatic do_msg(input bit glitch, input bit drop_start);
        bit             ok;
        logic [DSZ-1:0] d0;
        int             w;
        wait_req(1'b1, 60, ok);
        check("req_rise_timeout", 32'(ok), 32'd1);
        if (!ok) return;
        check("dat", 32'(dat), exp_dat(exp_n));
        check("red", 32'(red), exp_red(exp_n));
        check("src", 32'(src), MY);
        check("dst", 32'(dst), DST);
        check("sent_cnt", 32'(sent), exp_n);
        check("done_in_run", 32'(done), 32'd0);
        d0 = dat;
        if (glitch) begin
            ack = 1'b1;
            step();
            ack = 1'b0;
            repeat (3) step();
            check("glitch_req", 32'(req), 32'd1);
            check("glitch_cnt", 32'(sent), exp_n);
        end
        w = $urandom_range(0, 3);
        repeat (w) step();
        ack = 1'b1;
        wait_req(1'b0, 20, ok);
        check("req_fall_timeout", 32'(ok), 32'd1);
        check("dat_stable", 32'(dat), 32'(d0));
        w = $urandom_range(0, 3);
        repeat (w) step();
        ack = 1'b0;
        exp_n++;
        if (drop_start) start = 1'b0;
    endtask

    initial begin
        bit ok;
        bit saw;
        int k;
        int n;

        repeat (3) step();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_req", 32'(req), 32'd0);
        check("rst_dat", 32'(dat), 32'd0);
        check("rst_sent", 32'(sent), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef HCOUNTER_SOURCE_DBG_ERR_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        rst = 1'b0;
        step();
        check("ready_after_init", 32'(ready), 32'd1);

        // Full run ending with start low so done stays visible.
        start = 1'b1;
        exp_n = 0;
        for (int i = 0; i < NMSG; i++) begin
            do_msg($urandom_range(0, 3) == 0, i == NMSG - 1);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("done_set", 32'(done), 32'd1);
        check("run_sent", 32'(sent), NMSG);
        check("run_dat_wrap", 32'(dat), exp_dat(NMSG));
        repeat (5) step();
        check("idle_req", 32'(req), 32'd0);
        check("done_hold", 32'(done), 32'd1);

        // Stale ack in IDLE blocks start.
        ack = 1'b1;
        repeat (4) step();
        start = 1'b1;
        repeat (4) step();
        check("stale_block_req", 32'(req), 32'd0);
        check("stale_done_kept", 32'(done), 32'd1);
`ifdef HCOUNTER_SOURCE_DBG_ERR_EN
        check("stale_err", 32'(err), 32'd1);
        check("stale_err_dat", 32'(err_dat), exp_dat(NMSG));
        check("err_src", 32'(err_src), MY);
`endif
        ack = 1'b0;

        // Abort via start low during GAP.
        exp_n = 0;
        k = $urandom_range(1, NMSG - 1);
        for (int i = 0; i < k; i++) begin
            do_msg($urandom_range(0, 3) == 0, i == k - 1);
        end
        saw = 1'b0;
        repeat (15) begin
            step();
            if (req === 1'b1) saw = 1'b1;
        end
        check("abort_no_req", 32'(saw), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sent", 32'(sent), k);
        check("abort_dat", 32'(dat), exp_dat(k));

        // Restart, then reset in the middle of the third request.
        start = 1'b1;
        exp_n = 0;
        do_msg(1'b0, 1'b0);
        do_msg(1'b1, 1'b0);
        wait_req(1'b1, 60, ok);
        check("req3_timeout", 32'(ok), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(req), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_sent", 32'(sent), 32'd0);
        check("mid_rst_dat", 32'(dat), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        step();
        step();
        check("rst_held_ready", 32'(ready), 32'd0);
`ifdef HCOUNTER_SOURCE_DBG_ERR_EN
        check("rst_err_clr", 32'(err), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(ready), 32'd1);

        // Full run with start held: done pulses and a new run begins at once.
        exp_n = 0;
        for (int i = 0; i < NMSG; i++) begin
            do_msg($urandom_range(0, 3) == 0, 1'b0);
        end
        saw = 1'b0;
        n = 0;
        while (!saw && n < 20) begin
            if (done === 1'b1) saw = 1'b1;
            step();
            n++;
        end
        check("done_pulse", 32'(saw), 32'd1);
        exp_n = 0;
        do_msg(1'b0, 1'b1);
        repeat (10) step();
        check("final_sent", 32'(sent), 32'd1);
        check("final_done", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=timeout expected=finish");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
